// File: rtl/key_sched_ctrl_pkg.sv
// Shared definitions for the AES-256 key-schedule controller.
// Holds the controller FSM state encoding and the key/round-key widths
// used by key_sched_ctrl and round_key_bank.
package key_sched_ctrl_pkg;

  localparam int NUM_ROUND_KEYS = 15;
  localparam int ROUND_KEY_W    = 128;
  localparam int KEY_W          = 256;
  localparam int EXP_W          = 1920;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_ENG  = 3'd1,
    ST_WAIT_EXP = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_READY    = 3'd4,
    ST_ERR      = 3'd5
  } state_t;

endpackage

// File: rtl/round_key_bank.sv
// Round-key storage for the key-schedule controller.
// Latches all 15 round keys from the expansion engine's word bus in one
// cycle, exposes them combinationally in decryption order, and provides a
// registered serial read port in encryption numbering.
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-high reset, clears bank and read data
//   capture   load the bank from exp_words this cycle
//   exp_words engine output, round key r at [128r +: 128]
//   rk_addr   serial read index 0..14 (15 reads as zero)
//   dec_keys  bank in decryption order, slot j holds round key 14-j
//   rk_data   round key rk_addr, one cycle after rk_addr is sampled
module round_key_bank
  import key_sched_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture,
  input  logic [EXP_W-1:0]       exp_words,
  input  logic [3:0]             rk_addr,
  output logic [EXP_W-1:0]       dec_keys,
  output logic [ROUND_KEY_W-1:0] rk_data
);

  logic [ROUND_KEY_W-1:0] bank_reg [NUM_ROUND_KEYS];
  // Padded to the full address range so index 15 is a defined zero entry.
  logic [ROUND_KEY_W-1:0] read_mux [16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_ROUND_KEYS; r++) begin
        bank_reg[r] <= '0;
      end
    end else if (capture) begin
      for (int r = 0; r < NUM_ROUND_KEYS; r++) begin
        bank_reg[r] <= exp_words[ROUND_KEY_W*r +: ROUND_KEY_W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROUND_KEYS; gi++) begin : g_slot
      assign dec_keys[ROUND_KEY_W*gi +: ROUND_KEY_W] = bank_reg[NUM_ROUND_KEYS-1-gi];
      assign read_mux[gi] = bank_reg[gi];
    end
    for (gi = NUM_ROUND_KEYS; gi < 16; gi++) begin : g_pad
      assign read_mux[gi] = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_data <= '0;
    end else begin
      rk_data <= read_mux[rk_addr];
    end
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-256 key-schedule controller.
// Accepts a key, resets and starts an external expansion engine, waits for
// it with a timeout, captures the 15 round keys into round_key_bank and
// presents them in decryption order and through a serial read port.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   key_in, key_load    key and load request (accepted in IDLE/READY/ERR)
//   key_load_ack        one-cycle pulse after an accepted request
//   exp_reset_n         active-low reset to the engine
//   exp_key             registered key driven to the engine
//   exp_key_valid       key valid to the engine (WAIT_EXP only)
//   exp_done, exp_words engine completion and 60 expanded words
//   busy                RST_ENG, WAIT_EXP or CAPTURE
//   keys_ready          bank valid (READY only)
//   exp_error           sticky timeout flag, cleared on next accepted load
//   dec_keys            bank in decryption order
//   rk_addr, rk_data    serial round-key read (registered)
module key_sched_ctrl
  import key_sched_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int ENG_RST_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [KEY_W-1:0]       key_in,
  input  logic                   key_load,
  output logic                   key_load_ack,
  output logic                   exp_reset_n,
  output logic [KEY_W-1:0]       exp_key,
  output logic                   exp_key_valid,
  input  logic                   exp_done,
  input  logic [EXP_W-1:0]       exp_words,
  output logic                   busy,
  output logic                   keys_ready,
  output logic                   exp_error,
  output logic [EXP_W-1:0]       dec_keys,
  input  logic [3:0]             rk_addr,
  output logic [ROUND_KEY_W-1:0] rk_data
);

  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ECW = $clog2(ENG_RST_CYCLES + 1);
  localparam logic [TCW-1:0] TOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [ECW-1:0] ENG_LAST  = ECW'(ENG_RST_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [ECW-1:0]   eng_cnt_reg, eng_cnt_next;
  // Number of WAIT_EXP cycles already completed; zero marks the first cycle.
  logic [TCW-1:0]   tout_cnt_reg, tout_cnt_next;
  logic [KEY_W-1:0] exp_key_reg, exp_key_next;
  logic             ack_reg, ack_next;
  logic             error_reg, error_next;
  logic             capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      eng_cnt_reg  <= '0;
      tout_cnt_reg <= '0;
      exp_key_reg  <= '0;
      ack_reg      <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      eng_cnt_reg  <= eng_cnt_next;
      tout_cnt_reg <= tout_cnt_next;
      exp_key_reg  <= exp_key_next;
      ack_reg      <= ack_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    eng_cnt_next  = eng_cnt_reg;
    tout_cnt_next = tout_cnt_reg;
    exp_key_next  = exp_key_reg;
    ack_next      = 1'b0;
    error_next    = error_reg;
    capture       = 1'b0;
    busy          = 1'b0;
    keys_ready    = 1'b0;
    exp_reset_n   = 1'b0;
    exp_key_valid = 1'b0;

    case (state_reg)
      ST_IDLE, ST_READY, ST_ERR: begin
        keys_ready  = (state_reg == ST_READY);
        // Engine stays out of reset in READY so its outputs remain stable.
        exp_reset_n = (state_reg == ST_READY);
        if (key_load) begin
          state_next   = ST_RST_ENG;
          exp_key_next = key_in;
          ack_next     = 1'b1;
          error_next   = 1'b0;
          eng_cnt_next = '0;
        end
      end

      ST_RST_ENG: begin
        busy = 1'b1;
        if (eng_cnt_reg == ENG_LAST) begin
          state_next    = ST_WAIT_EXP;
          eng_cnt_next  = '0;
          tout_cnt_next = '0;
        end else begin
          eng_cnt_next = eng_cnt_reg + ECW'(1);
        end
      end

      ST_WAIT_EXP: begin
        busy          = 1'b1;
        exp_reset_n   = 1'b1;
        exp_key_valid = 1'b1;
        // exp_done in the first cycle may still be left over from the
        // previous key, so it only counts once the counter has advanced.
        // Checked before the timeout so a coinciding done wins.
        if (exp_done && (tout_cnt_reg != '0)) begin
          state_next = ST_CAPTURE;
        end else if (tout_cnt_reg == TOUT_LAST) begin
          state_next = ST_ERR;
          error_next = 1'b1;
        end else begin
          tout_cnt_next = tout_cnt_reg + TCW'(1);
        end
      end

      ST_CAPTURE: begin
        busy        = 1'b1;
        exp_reset_n = 1'b1;
        capture     = 1'b1;
        state_next  = ST_READY;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign key_load_ack = ack_reg;
  assign exp_key      = exp_key_reg;
  assign exp_error    = error_reg;

  round_key_bank u_bank (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .exp_words (exp_words),
    .rk_addr   (rk_addr),
    .dec_keys  (dec_keys),
    .rk_data   (rk_data)
  );

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: a behavioural engine stand-in,
// a transaction-level reference model and randomized plus directed stimulus.
module tb_key_sched_ctrl;

  localparam int ENG  = 2;
  localparam int TOUT = 200;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [255:0]   key_in = '0;
  logic           key_load = 1'b0;
  logic           key_load_ack;
  logic           exp_reset_n;
  logic [255:0]   exp_key;
  logic           exp_key_valid;
  logic           exp_done = 1'b0;
  logic [1919:0]  exp_words = '0;
  logic           busy;
  logic           keys_ready;
  logic           exp_error;
  logic [1919:0]  dec_keys;
  logic [3:0]     rk_addr = '0;
  logic [127:0]   rk_data;

  always #5 clk = ~clk;

  key_sched_ctrl #(
    .TIMEOUT_CYCLES (TOUT),
    .ENG_RST_CYCLES (ENG)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_in        (key_in),
    .key_load      (key_load),
    .key_load_ack  (key_load_ack),
    .exp_reset_n   (exp_reset_n),
    .exp_key       (exp_key),
    .exp_key_valid (exp_key_valid),
    .exp_done      (exp_done),
    .exp_words     (exp_words),
    .busy          (busy),
    .keys_ready    (keys_ready),
    .exp_error     (exp_error),
    .dec_keys      (dec_keys),
    .rk_addr       (rk_addr),
    .rk_data       (rk_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stand-in key expansion: round keys 0/1 are the two key halves, later
  // ones a cheap mix of earlier ones. Only distinctness matters here.
  function automatic logic [1919:0] expand(input logic [255:0] k);
    logic [127:0]  w [15];
    logic [1919:0] res;
    w[0] = k[255:128];
    w[1] = k[127:0];
    for (int r = 2; r < 15; r++) begin
      w[r] = w[r-2] ^ {w[r-1][119:0], w[r-1][127:120]} ^ 128'(r);
    end
    for (int r = 0; r < 15; r++) begin
      res[128*r +: 128] = w[r];
    end
    return res;
  endfunction

  // ---------------- engine stand-in ----------------
  int eng_lat   = -1;   // valid cycles until done; -1 = never
  bit eng_stale = 1'b0; // keep done high through reset and first valid cycle
  int eng_cnt   = 0;

  task automatic engine_update();
    bit fresh;
    if (!exp_reset_n) eng_cnt = 0;
    else if (exp_key_valid) eng_cnt++;
    if (eng_stale && eng_cnt >= 2) eng_stale = 1'b0;
    fresh = (eng_lat > 0) && (eng_cnt >= eng_lat);
    if (fresh) exp_words = expand(exp_key);
    exp_done = fresh || eng_stale;
  endtask

  // ---------------- reference model ----------------
  // m_n: cycles since the accepting edge (0 = no expansion in flight).
  // Cycles 1..ENG hold the engine in reset, the next TOUT cycles wait.
  int           m_n;
  bit           m_cap, m_ready, m_err, m_ack;
  logic [255:0] m_key;
  logic [127:0] m_bank [15];
  logic [127:0] m_rd;

  task automatic model_reset();
    m_n = 0; m_cap = 0; m_ready = 0; m_err = 0; m_ack = 0;
    m_key = '0; m_rd = '0;
    for (int r = 0; r < 15; r++) m_bank[r] = '0;
  endtask

  task automatic model_edge();
    int w;
    logic [1919:0] words;
    m_rd  = (rk_addr < 4'd15) ? m_bank[rk_addr] : 128'h0;
    m_ack = 0;
    if (m_cap) begin
      words = expand(m_key);
      for (int r = 0; r < 15; r++) m_bank[r] = words[128*r +: 128];
      m_cap = 0;
      m_ready = 1;
    end else if (m_n > 0) begin
      w = m_n - ENG;
      if (w >= 2 && exp_done) begin
        m_n = 0; m_cap = 1;
      end else if (w == TOUT) begin
        m_n = 0; m_err = 1;
      end else begin
        m_n++;
      end
    end else if (key_load) begin
      m_n = 1; m_key = key_in; m_ack = 1; m_err = 0; m_ready = 0;
    end
  endtask

  task automatic compare_all();
    check("ack", key_load_ack, m_ack);
    check("busy", busy, (m_n > 0) || m_cap);
    check("keys_ready", keys_ready, m_ready);
    check("exp_error", exp_error, m_err);
    check("exp_key", exp_key, m_key);
    check("rk_data", rk_data, m_rd);
    if (m_n > 0 && m_n <= ENG) begin
      check("rstn_in_rst", exp_reset_n, 0);
      check("valid_in_rst", exp_key_valid, 0);
    end else if (m_n > ENG) begin
      check("rstn_in_wait", exp_reset_n, 1);
      check("valid_in_wait", exp_key_valid, 1);
    end else if (!m_cap && !m_ready) begin
      check("rstn_idle_err", exp_reset_n, 0);
      check("valid_idle_err", exp_key_valid, 0);
    end
    for (int j = 0; j < 15; j++) begin
      check($sformatf("dec%0d", j), dec_keys[128*j +: 128], m_bank[14-j]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    engine_update();
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      rk_addr = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  task automatic load(input logic [255:0] k, input int lat, input bit stale);
    key_in = k; key_load = 1'b1; eng_lat = lat; eng_stale = stale;
    tick();
    key_load = 1'b0; key_in = rand256();
    $display("load key=%h latency=%0d stale=%0d", k, lat, stale);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0]  k;
    logic [1919:0] words;
    int cnt;

    model_reset();
    // Reset with a load request pending: must not be accepted.
    reset = 1'b1; key_load = 1'b1; key_in = rand256();
    repeat (3) tick();
    #2 reset = 1'b0; key_load = 1'b0;
    run(3);

    // Known-answer load: 00..1F bytes, done 80 cycles into the wait.
    k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    load(k, 80, 0);
    cnt = 0;
    while (!exp_reset_n && cnt < 10) begin cnt++; tick(); end
    check("rst_len", 256'(cnt), 256'(ENG));
    cnt = 0;
    while (!exp_done && cnt < 300) begin cnt++; tick(); end
    check("done_seen", exp_done, 1);
    cnt = 0;
    while (!keys_ready && cnt < 10) begin cnt++; tick(); end
    check("ready_lat", 256'(cnt), 256'd2);
    rk_addr = 4'd0;
    tick();
    check("rk0_kat", rk_data, 128'h000102030405060708090a0b0c0d0e0f);
    words = expand(k);
    check("dec0_is_rk14", dec_keys[127:0], words[128*14 +: 128]);

    // Load held through the whole wait: one ack, key stays put.
    key_load = 1'b1; key_in = rand256(); eng_lat = 40; eng_stale = 1'b0;
    tick();
    check("ready_drop", keys_ready, 0);
    repeat (30) begin key_in = rand256(); tick(); end
    key_load = 1'b0;
    run(30);

    // Timeout, then recovery clears the flag together with the ack.
    load(rand256(), -1, 0);
    run(ENG + TOUT + 3);
    check("err_flag", exp_error, 1);
    check("err_not_ready", keys_ready, 0);
    load(rand256(), 20, 0);
    check("err_clear_on_ack", {key_load_ack, exp_error}, 2'b10);
    run(30);

    // Stale done from the previous key across the reload.
    load(rand256(), 10, 1);
    run(20);

    // Done in the last wait cycle beats the timeout.
    load(rand256(), TOUT, 0);
    run(ENG + TOUT + 3);
    check("coincide_no_err", exp_error, 0);
    check("coincide_ready", keys_ready, 1);
    rk_addr = 4'd15;
    tick();
    check("rk15_zero", rk_data, 0);

    // Asynchronous reset in wait cycle 40.
    load(rand256(), -1, 0);
    run(ENG + 39);
    #3 reset = 1'b1;
    #1 model_reset();
    check("arst_ack", key_load_ack, 0);
    check("arst_rstn", exp_reset_n, 0);
    check("arst_key", exp_key, 0);
    check("arst_valid", exp_key_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", keys_ready, 0);
    check("arst_err", exp_error, 0);
    check("arst_rk", rk_data, 0);
    check("arst_dec0", dec_keys[127:0], 0);
    key_load = 1'b1; key_in = rand256(); eng_lat = 15; eng_stale = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    tick();
    key_load = 1'b0;
    run(40);

    // Randomized traffic with load noise while busy.
    for (int c = 0; c < 4000; c++) begin
      rk_addr = 4'($urandom_range(0, 15));
      key_in = rand256();
      if (m_n == 0 && !m_cap) begin
        key_load = ($urandom_range(0, 3) == 0);
        if (key_load) begin
          case ($urandom_range(0, 9))
            0: eng_lat = -1;
            1: eng_lat = TOUT;
            2: eng_lat = TOUT + 1;
            default: eng_lat = int'($urandom_range(1, 60));
          endcase
          eng_stale = $urandom_range(0, 1) == 1;
          $display("load key=%h latency=%0d stale=%0d", key_in, eng_lat, eng_stale);
        end
      end else begin
        key_load = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    key_load = 1'b0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 200: max cycles in WAIT_EXP before error.
REQ-002 SHALL provide parameter ENG_RST_CYCLES, default 2: cycles the expansion engine is held in reset.
REQ-003 SHALL have ports, in order:
 clk  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-high
 key_in  in  256  AES-256 key, bit 0 = MSB
 key_load  in  1  request to load key_in
 key_load_ack  out  1  one-cycle pulse, request accepted
 exp_reset_n  out  1  synchronous active-low reset to expansion engine
 exp_key  out  256  key driven to engine
 exp_key_valid  out  1  key valid to engine
 exp_done  in  1  engine expansion complete
 exp_words  in  1920  engine's 60 words, bit 0 = MSB of word 0
 busy  out  1  high in RST_ENG, WAIT_EXP, CAPTURE
 keys_ready  out  1  round-key bank valid
 exp_error  out  1  sticky timeout flag
 dec_keys  out  1920  bank in decryption order
 rk_addr  in  4  serial read index (encryption numbering)
 rk_data  out  128  registered serial read data

Function
REQ-004 SHALL implement FSM states IDLE, RST_ENG, WAIT_EXP, CAPTURE, READY, ERR.
REQ-005 SHALL accept key_load in IDLE, READY or ERR only; acceptance pulses key_load_ack next cycle, registers key_in into exp_key, enters RST_ENG.
REQ-006 SHALL ignore key_load in RST_ENG, WAIT_EXP, CAPTURE (no ack, no queuing).
REQ-007 RST_ENG: exp_reset_n=0, exp_key_valid=0 for exactly ENG_RST_CYCLES cycles, then WAIT_EXP.
REQ-008 WAIT_EXP: exp_reset_n=1, exp_key_valid=1, exp_key stable; timeout counter increments each cycle.
REQ-009 exp_done SHALL be ignored in RST_ENG and in the first WAIT_EXP cycle (stale value from prior key).
REQ-010 exp_done=1 in WAIT_EXP (after first cycle) SHALL move to CAPTURE; if counter reaches TIMEOUT_CYCLES first, enter ERR and set exp_error.
REQ-011 exp_done and timeout in the same cycle: exp_done wins.
REQ-012 CAPTURE (one cycle): latch round key r = exp_words[128r +:128], r=0..14, into bank; next state READY.
REQ-013 keys_ready SHALL be 1 only in READY; falls the cycle after a new key_load is accepted; bank holds old contents until CAPTURE overwrites.
REQ-014 dec_keys[128j +:128] SHALL equal bank round key 14-j, j=0..14, combinationally from bank.
REQ-015 rk_data SHALL equal round key rk_addr one cycle after rk_addr is sampled; rk_addr 15 returns zero; readable in any state.
REQ-016 exp_error SHALL stay set in ERR and clear on the ack of the next accepted key_load.
REQ-017 In IDLE and ERR: exp_reset_n=0, exp_key_valid=0.

Reset
REQ-018 Reset assertion SHALL asynchronously force IDLE from any state, incl. mid-expansion.
REQ-019 Reset values: key_load_ack=0, exp_reset_n=0, exp_key=0, exp_key_valid=0, busy=0, keys_ready=0, exp_error=0, bank=0 (dec_keys=0), rk_data=0, counters=0.
REQ-020 Reset deassertion SHALL take effect on the next rising clk edge; no key_load accepted before it.

Structure
REQ-021 Shared package SHALL hold FSM state encoding, NUM_ROUND_KEYS=15, ROUND_KEY_W=128, KEY_W=256, EXP_W=1920.
REQ-022 Round-key bank and serial read port SHALL be one sub-module, round_key_bank; FSM stays in key_sched_ctrl.
REQ-023 Expansion engine SHALL be instantiated outside this block, connected by ports only.

Verification
REQ-024 Reset, key_load with key_in=00..1F bytes, engine model raising exp_done 80 cycles later -> ack 1 cycle after request, exp_reset_n low 2 cycles, keys_ready rises 2 cycles after exp_done, rk_addr=0 -> rk_data=000102..0F, dec_keys[0:127] = words 56..59.
REQ-025 Engine never raises exp_done -> ERR after 200 WAIT_EXP cycles, exp_error=1, keys_ready=0; next key_load clears exp_error on ack.
REQ-026 key_load held continuously during WAIT_EXP -> no extra ack, exp_key unchanged; in READY -> single ack, keys_ready drops next cycle.
REQ-027 Reset asserted mid-WAIT_EXP (cycle 40) -> all outputs at reset values without clock edge, FSM IDLE.
REQ-028 exp_done held high from prior key during reload -> ignored in RST_ENG and first WAIT_EXP cycle; CAPTURE only on fresh assertion after first cycle.
REQ-029 exp_done and timeout coincide at cycle 200 -> CAPTURE, exp_error stays 0; rk_addr=15 -> rk_data=0.
